// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt front-end: source count, id width
// and the request-handshake state encoding.
package irq_pkg;

  localparam int IRQ_N    = 8;
  localparam int IRQ_ID_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-index-wins priority encoder; valid is low when no bit is set.
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: edge-detected pending bits, mask, in-service nesting
// and a registered req/ack presentation of the highest eligible source.
//
//   state | meaning
//   IDLE  | no request presented; selects highest eligible source each cycle
//   REQ   | irq_req high, irq_id frozen until the CPU acks
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int             N        = IRQ_N,
  parameter int             ID_W     = IRQ_ID_W,
  parameter logic [N-1:0]   MASK_RST = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    irq_in,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_wdata,
  output logic            irq_req,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack,
  input  logic            eoi,
  input  logic [ID_W-1:0] eoi_id,
  output logic [N-1:0]    pending_o,
  output logic [N-1:0]    isr_o,
  output logic [N-1:0]    mask_o
);

  irq_state_e      state, state_nxt;
  logic [N-1:0]    irq_in_q, pending, isr, mask;
  logic [N-1:0]    rise, ack_set, eoi_clr, above, eligible;
  logic [ID_W-1:0] id_q, elig_id, hi_isr;
  logic            elig_vld, isr_vld, ack_fire;

  assign rise     = irq_in & ~irq_in_q;
  assign ack_fire = (state == REQ) && irq_ack;
  assign ack_set  = ack_fire ? (N'(1) << id_q) : '0;
  assign eoi_clr  = eoi ? (N'(1) << eoi_id) : '0;

  // Nesting: only sources strictly above the highest in-service one qualify.
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = !isr_vld || (i > int'(hi_isr));
    end
  end

  assign eligible = pending & ~mask & above;

  irq_prio_enc #(.N(N), .ID_W(ID_W)) u_enc_elig (
    .vec   (eligible),
    .id    (elig_id),
    .valid (elig_vld)
  );

  irq_prio_enc #(.N(N), .ID_W(ID_W)) u_enc_isr (
    .vec   (isr),
    .id    (hi_isr),
    .valid (isr_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (elig_vld) state_nxt = REQ;
      REQ:  if (irq_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq_req = (state == REQ);
    irq_id  = id_q;
  end

  always_ff @(posedge clk) begin
    if (rst)                          id_q <= '0;
    else if (state == IDLE && elig_vld) id_q <= elig_id;
  end

  // Set beats clear on coincidence for both pending (rise vs ack) and isr (ack vs eoi).
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_in_q <= '0;
      pending  <= '0;
      isr      <= '0;
      mask     <= MASK_RST;
    end else begin
      irq_in_q <= irq_in;
      pending  <= (pending & ~ack_set) | rise;
      isr      <= (isr & ~eoi_clr) | ack_set;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign pending_o = pending;
  assign isr_o     = isr;
  assign mask_o    = mask;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed scenarios plus random traffic, checked against a cycle-level
// behavioural model of the interrupt front-end.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic       eoi;
  logic [2:0] eoi_id;
  logic [7:0] pending_o, isr_o, mask_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_pend, m_isr, m_mask, m_prev;
  logic       m_req;
  int         m_id;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .eoi_id     (eoi_id),
    .pending_o  (pending_o),
    .isr_o      (isr_o),
    .mask_o     (mask_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock of the reference: what the controller should hold after this edge.
  task automatic model_edge();
    logic [7:0] nxt_pend, nxt_isr;
    int         hi, best;
    bit         acked;
    if (rst) begin
      m_pend = '0; m_isr = '0; m_mask = 8'hFF; m_prev = '0;
      m_req  = 1'b0; m_id = 0;
      return;
    end
    acked = m_req && irq_ack;
    hi    = top_bit(m_isr);
    best  = -1;
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && !m_mask[i] && i > hi) best = i;
    nxt_pend = m_pend;
    if (acked) nxt_pend[m_id] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (irq_in[i] && !m_prev[i]) nxt_pend[i] = 1'b1;
    nxt_isr = m_isr;
    if (eoi) nxt_isr[eoi_id] = 1'b0;
    if (acked) nxt_isr[m_id] = 1'b1;
    if (m_req) begin
      if (acked) m_req = 1'b0;
    end else if (best >= 0) begin
      m_req = 1'b1;
      m_id  = best;
    end
    if (mask_we) m_mask = mask_wdata;
    m_pend = nxt_pend;
    m_isr  = nxt_isr;
    m_prev = irq_in;
  endtask

  task automatic compare_model();
    check("req", 32'(irq_req), 32'(m_req));
    if (m_req) check("id", 32'(irq_id), 32'(m_id));
    check("pending", 32'(pending_o), 32'(m_pend));
    check("isr", 32'(isr_o), 32'(m_isr));
    check("mask", 32'(mask_o), 32'(m_mask));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    irq_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; rst = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; step();
  endtask

  task automatic do_eoi(input logic [2:0] id);
    eoi = 1'b1; eoi_id = id; step();
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0; eoi_id = '0;
    step();
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pend", 32'(pending_o), 32'h00);
    check("rst_mask", 32'(mask_o), 32'hFF);

    // Single source, two-cycle latency, ack moves it to in-service.
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    irq_in = 8'h08; step();
    check("lat_k_req", 32'(irq_req), 32'd0);
    step();
    check("lat_k1_req", 32'(irq_req), 32'd1);
    check("lat_k1_id", 32'(irq_id), 32'd3);
    do_ack();
    check("ack3_pend", 32'(pending_o), 32'h00);
    check("ack3_isr", 32'(isr_o), 32'h08);

    // Nesting: 5 preempts 3, 1 waits until both are retired.
    irq_in = 8'h22; step(); step();
    check("nest_id5", 32'(irq_id), 32'd5);
    do_ack(); step();
    check("nest_blocked", 32'(irq_req), 32'd0);
    do_eoi(3'd3); step();
    check("nest_still", 32'(irq_req), 32'd0);
    do_eoi(3'd5); step();
    check("nest_id1_req", 32'(irq_req), 32'd1);
    check("nest_id1", 32'(irq_id), 32'd1);
    do_ack(); do_eoi(3'd1);
    irq_in = 8'h00; step();

    // Masked source stays pending, fires one cycle after unmask.
    mask_we = 1'b1; mask_wdata = 8'h80; step();
    irq_in = 8'h80; step(); step(); step();
    check("mask_noreq", 32'(irq_req), 32'd0);
    check("mask_pend", 32'(pending_o), 32'h80);
    mask_we = 1'b1; mask_wdata = 8'h00; step(); step();
    check("unmask_req", 32'(irq_req), 32'd1);
    check("unmask_id", 32'(irq_id), 32'd7);
    do_ack(); do_eoi(3'd7);
    irq_in = 8'h00; step();

    // Presented id frozen while a higher source arrives.
    irq_in = 8'h04; step(); step();
    irq_in = 8'h44; step(); step();
    check("hold_id", 32'(irq_id), 32'd2);
    check("hold_req", 32'(irq_req), 32'd1);
    do_ack(); step();
    check("after_hold_id", 32'(irq_id), 32'd6);
    check("after_hold_req", 32'(irq_req), 32'd1);
    do_ack(); do_eoi(3'd6); do_eoi(3'd2);
    irq_in = 8'h00; step();

    // Rise coinciding with ack on the same bit, then reset mid-request.
    irq_in = 8'h10; step();
    irq_in = 8'h00; step();
    check("co_req_id", 32'(irq_id), 32'd4);
    irq_in = 8'h10; do_ack();
    check("co_pend4", 32'(pending_o[4]), 32'd1);
    check("co_isr4", 32'(isr_o[4]), 32'd1);
    irq_in = 8'h90; step(); step();
    check("pre_rst_req", 32'(irq_req), 32'd1);
    rst = 1'b1; step();
    check("midrst_req", 32'(irq_req), 32'd0);
    check("midrst_id", 32'(irq_id), 32'd0);
    check("midrst_pend", 32'(pending_o), 32'h00);
    check("midrst_isr", 32'(isr_o), 32'h00);
    check("midrst_mask", 32'(mask_o), 32'hFF);

    // Random traffic against the model.
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    for (int c = 0; c < 3000; c++) begin
      irq_in  = irq_in ^ (8'($urandom) & 8'($urandom));
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      eoi_id  = 3'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        mask_we    = 1'b1;
        mask_wdata = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
      irq_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
